// File: rtl/alu_exec_unit.sv
// Execute-stage unit: single-cycle logic/arithmetic ops plus an iterative 1-bit-per-cycle SLL/SRL.
// A start/busy/done handshake lets the pipeline stall while a shift is in flight.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; op results are computed on acceptance
// ST_SHIFT | shifting one bit per cycle, counter walks down to 1
// ST_DONE  | result/zero/invalid_op valid, done pulses for one cycle
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             alu_operation,
    input  logic [1:0]             shift_op,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  a,
    input  logic [DATA_WIDTH-1:0]  b,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   zero,
    output logic                   invalid_op
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                    shl_q, shl_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    zero_q, zero_d;
    logic                    invalid_q, invalid_d;

    logic                    fin;
    logic [DATA_WIDTH-1:0]   fin_val;
    logic                    fin_inv;
    logic [DATA_WIDTH-1:0]   shifted;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        shl_d     = shl_q;
        result_d  = result_q;
        zero_d    = zero_q;
        invalid_d = invalid_q;
        fin       = 1'b0;
        fin_val   = '0;
        fin_inv   = 1'b0;
        shifted   = shl_q ? (shreg_q << 1) : (shreg_q >> 1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (shift_op)
                        2'b01, 2'b10: begin
                            if (shamt != '0) begin
                                shreg_d = b;
                                cnt_d   = shamt;
                                shl_d   = (shift_op == 2'b01);
                                state_d = ST_SHIFT;
                            end else begin
                                fin     = 1'b1;
                                fin_val = b;
                            end
                        end
                        2'b11: begin
                            fin     = 1'b1;
                            fin_inv = 1'b1;
                        end
                        default: begin
                            fin = 1'b1;
                            case (alu_operation)
                                3'b000:  fin_val = a & b;
                                3'b001:  fin_val = a | b;
                                3'b010:  fin_val = ~(a | b);
                                3'b011:  fin_val = a + b;
                                3'b100:  fin_val = a - b;
                                3'b101:  fin_val = b << 16;
                                3'b110:  fin_val = a;
                                default: fin_inv = 1'b1;
                            endcase
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    fin     = 1'b1;
                    fin_val = shifted;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every path that finishes an op lands in DONE with fresh flags.
        if (fin) begin
            state_d   = ST_DONE;
            result_d  = fin_val;
            zero_d    = (fin_val == '0);
            invalid_d = fin_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            shl_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            shl_q     <= shl_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            invalid_q <= invalid_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign result     = result_q;
    assign zero       = zero_q;
    assign invalid_op = invalid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected results and latencies.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  alu_operation;
    logic [1:0]  shift_op;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        invalid_op;

    int total = 0;
    int bad   = 0;

    alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .alu_operation (alu_operation),
        .shift_op      (shift_op),
        .shamt         (shamt),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .zero          (zero),
        .invalid_op    (invalid_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; start is held for exactly one edge.
    task automatic launch(input logic [2:0] op, input logic [1:0] sop, input logic [4:0] sh,
                          input logic [31:0] aa, input logic [31:0] bb);
        alu_operation = op;
        shift_op      = sop;
        shamt         = sh;
        a             = aa;
        b             = bb;
        start         = 1'b1;
        step();
        start         = 1'b0;
    endtask

    // Latency counts cycles from the accepting edge; returns one cycle after done.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        int lat;
        int nbusy;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 200) begin
            if (busy) nbusy++;
            step();
            lat++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        step();
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        int first_done;

        reset = 1'b0;
        start = 1'b0;
        alu_operation = 3'b000;
        shift_op = 2'b00;
        shamt = 5'd0;
        a = 32'd0;
        b = 32'd0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_invalid", 32'(invalid_op), 32'd0);
        reset = 1'b1;
        step();

        launch(3'b011, 2'b00, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_result", result, 32'h8000_0000);
        chk("add_zero", 32'(zero), 32'd0);
        wait_done("add", 1, 0);

        launch(3'b100, 2'b00, 5'd0, 32'h1234_5678, 32'h1234_5678);
        chk("sub_result", result, 32'h0000_0000);
        chk("sub_zero", 32'(zero), 32'd1);
        wait_done("sub", 1, 0);

        launch(3'b010, 2'b00, 5'd0, 32'h0, 32'h0);
        chk("nor_result", result, 32'hFFFF_FFFF);
        chk("nor_zero", 32'(zero), 32'd0);
        wait_done("nor", 1, 0);

        launch(3'b000, 2'b00, 5'd0, 32'hF0F0_1234, 32'hFF00_00FF);
        chk("and_result", result, 32'hF000_0034);
        wait_done("and", 1, 0);

        launch(3'b001, 2'b00, 5'd0, 32'hF0F0_1234, 32'h0F00_00C0);
        chk("or_result", result, 32'hFFF0_12F4);
        wait_done("or", 1, 0);

        launch(3'b110, 2'b00, 5'd0, 32'h0040_0108, 32'h1111_1111);
        chk("jal_result", result, 32'h0040_0108);
        wait_done("jal", 1, 0);

        launch(3'b011, 2'b01, 5'd31, 32'h0, 32'h0000_0001);
        wait_done("sll31", 32, 31);
        chk("sll31_result", result, 32'h8000_0000);

        launch(3'b011, 2'b10, 5'd4, 32'h0, 32'h8000_0000);
        wait_done("srl4", 5, 4);
        chk("srl4_result", result, 32'h0800_0000);

        launch(3'b011, 2'b10, 5'd0, 32'h0, 32'hDEAD_BEEF);
        wait_done("srl0", 1, 0);
        chk("srl0_result", result, 32'hDEAD_BEEF);

        launch(3'b011, 2'b11, 5'd3, 32'h5, 32'h7);
        wait_done("sop11", 1, 0);
        chk("sop11_result", result, 32'h0);
        chk("sop11_invalid", 32'(invalid_op), 32'd1);

        launch(3'b111, 2'b00, 5'd0, 32'h5, 32'h7);
        wait_done("op111", 1, 0);
        chk("op111_result", result, 32'h0);
        chk("op111_invalid", 32'(invalid_op), 32'd1);
        chk("op111_zero", 32'(zero), 32'd1);

        // Start during SHIFT must be dropped and a changed b must not leak in.
        launch(3'b000, 2'b01, 5'd8, 32'h0, 32'h0000_00FF);
        alu_operation = 3'b011;
        shift_op      = 2'b00;
        a             = 32'h1;
        b             = 32'h2;
        start         = 1'b1;
        ndone         = 0;
        first_done    = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = c;
            end
            step();
            start = 1'b0;
            b     = 32'hFFFF_0000;
        end
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_done_cycle", 32'(first_done), 32'd9);
        chk("ign_result", result, 32'h0000_FF00);
        chk("ign_invalid", 32'(invalid_op), 32'd0);

        // Reset during a shift abandons it with no done pulse.
        launch(3'b000, 2'b01, 5'd20, 32'h0, 32'h0000_0001);
        repeat (9) step();
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_result", result, 32'h0);
        chk("mid_done", 32'(done), 32'd0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (done) ndone++;
            step();
        end
        chk("mid_no_done", 32'(ndone), 32'd0);

        launch(3'b101, 2'b00, 5'd0, 32'h0, 32'h0000_ABCD);
        wait_done("lui", 1, 0);
        chk("lui_result", result, 32'hABCD_0000);
        chk("lui_invalid", 32'(invalid_op), 32'd0);
        chk("lui_zero", 32'(zero), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
